execute_stage2_pipe: RTL and testbench

- Parametrised second pipeline stage (decode-to-writeback) of the MaxiCore32 pipeline; next generation of the current stage-2 block.
- Latches ALU flags, evaluates branch conditions, sign/zero-extends loads, issues register-file write strobes and jumps.
- Adds valid/ready handshakes on both sides, multi-cycle load wait on memory data, and a parametrised post-jump squash shadow.

---
 rtl/execute_stage2_pipe_pkg.sv | 61 ++++++
 rtl/execute_stage2_pipe_cond_eval.sv | 37 +++
 rtl/execute_stage2_pipe.sv | 178 +++++++++++++++++
 tb/tb_execute_stage2_pipe.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_stage2_pipe_pkg.sv
// Shared types for the MaxiCore32 stage-2 slice: opcodes, condition codes,
// load widths, immediate types and the stage state.
package execute_stage2_pipe_pkg;

   typedef enum logic [4:0] {
      OPCODE_NOP    = 5'h00,
      OPCODE_ALU    = 5'h01,
      OPCODE_ALUM   = 5'h02,
      OPCODE_ALUMI  = 5'h03,
      OPCODE_LOAD   = 5'h04,
      OPCODE_LOADI  = 5'h05,
      OPCODE_STORE  = 5'h06,
      OPCODE_BRANCH = 5'h07,
      OPCODE_JUMP   = 5'h08
   } t_opcode;

   typedef enum logic [3:0] {
      COND_AL = 4'h0,
      COND_EQ = 4'h1,
      COND_NE = 4'h2,
      COND_CS = 4'h3,
      COND_CC = 4'h4,
      COND_MI = 4'h5,
      COND_PL = 4'h6,
      COND_VS = 4'h7,
      COND_VC = 4'h8,
      COND_HI = 4'h9,
      COND_LS = 4'hA,
      COND_GE = 4'hB,
      COND_LT = 4'hC,
      COND_GT = 4'hD,
      COND_LE = 4'hE,
      COND_NV = 4'hF
   } t_alu_condition;

   // CW_WORD is a 16-bit halfword; DWORD/QWORD both load the low 32 bits
   localparam logic [1:0] CW_BYTE  = 2'd0;
   localparam logic [1:0] CW_WORD  = 2'd1;
   localparam logic [1:0] CW_DWORD = 2'd2;
   localparam logic [1:0] CW_QWORD = 2'd3;

   typedef enum logic [1:0] {
      IT_UNSIGNED = 2'd0,
      IT_SIGNED   = 2'd1,
      IT_HIGH     = 2'd2,
      IT_LOW      = 2'd3
   } t_immediate_type;

   typedef enum logic {
      RUN      = 1'b0,
      WAIT_MEM = 1'b1
   } t_stage_state;

   localparam logic [31:0] NOP_WORD = {OPCODE_NOP, 27'h0};

   function automatic logic is_alu_op(input logic [4:0] op);
      return (op == OPCODE_ALU) || (op == OPCODE_ALUM) ||
             (op == OPCODE_ALUMI);
   endfunction

endpackage

// File: rtl/execute_stage2_pipe_cond_eval.sv
// Condition-code evaluator: condition + {N,Z,C,V} -> taken.
// Purely combinational so later stages can reuse it.
module execute_stage2_pipe_cond_eval
   import execute_stage2_pipe_pkg::*;
(
   input  logic [3:0] condition,
   input  logic [3:0] flags,
   output logic       taken
);

   logic n, z, c, v;

   assign {n, z, c, v} = flags;

   always_comb begin
      taken = 1'b0;
      case (condition)
         COND_AL: taken = 1'b1;
         COND_EQ: taken = z;
         COND_NE: taken = ~z;
         COND_CS: taken = c;
         COND_CC: taken = ~c;
         COND_MI: taken = n;
         COND_PL: taken = ~n;
         COND_VS: taken = v;
         COND_VC: taken = ~v;
         COND_HI: taken = ~c & ~z;
         COND_LS: taken = c | z;
         COND_GE: taken = ~(n ^ v);
         COND_LT: taken = n ^ v;
         COND_GT: taken = ~z & ~(n ^ v);
         COND_LE: taken = z | (n ^ v);
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/execute_stage2_pipe.sv
// MaxiCore32 stage 2: flags, branches, load extension, writeback strobes.
// Optional FLAG_SET_SELECT_EN: ALU ops update flags only when bit [24] is set.
module execute_stage2_pipe
   import execute_stage2_pipe_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int REG_INDEX_WIDTH = 4,
   parameter int BRANCH_SHADOW   = 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                inbound_instruction,
   input  logic [ADDR_WIDTH-1:0]      inbound_address,
   input  logic [DATA_WIDTH-1:0]      data_in,
   input  logic                       data_in_valid,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                outbound_instruction,
   output logic [ADDR_WIDTH-1:0]      outbound_address,
   output logic                       write,
   output logic [REG_INDEX_WIDTH-1:0] write_index,
   output logic [DATA_WIDTH-1:0]      write_data,
   output logic                       write_immediate,
   output logic [15:0]                write_immediate_data,
   output logic [1:0]                 write_immediate_type,
   output logic                       alu_cycle,
   input  logic [DATA_WIDTH-1:0]      alu_result,
   output logic [DATA_WIDTH-1:0]      alu_result_latched,
   input  logic                       alu_carry_out,
   input  logic                       alu_zero_out,
   input  logic                       alu_neg_out,
   input  logic                       alu_over_out,
   output logic                       alu_carry_in,
   output logic                       jump,
   output logic [3:0]                 flags
);

   t_stage_state               state, state_next;
   logic [7:0]                 shadow;
   logic [4:0]                 opcode;
   logic [REG_INDEX_WIDTH-1:0] index;
   logic                       accept, squash, taken, flag_en;

   assign opcode   = inbound_instruction[31:27];
   assign index    = inbound_instruction[20 +: REG_INDEX_WIDTH];
   assign in_ready = (state == RUN) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign squash   = shadow != 8'd0;

`ifdef FLAG_SET_SELECT_EN
   assign flag_en = inbound_instruction[24];
`else
   assign flag_en = 1'b1;
`endif

   execute_stage2_pipe_cond_eval u_cond_eval (
      .condition (inbound_instruction[15:12]),
      .flags     (flags),
      .taken     (taken)
   );

   function automatic logic [DATA_WIDTH-1:0] load_ext(
      input logic [1:0]  cw,
      input logic        sgn,
      input logic [31:0] d
   );
      logic [63:0] v;
      case (cw)
         CW_BYTE: v = {{56{sgn & d[7]}}, d[7:0]};
         CW_WORD: v = {{48{sgn & d[15]}}, d[15:0]};
         default: v = {{32{sgn & d[31]}}, d[31:0]};
      endcase
      return DATA_WIDTH'(v);
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= RUN;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         RUN:
            if (accept && !squash && opcode == OPCODE_LOAD &&
                !data_in_valid)
               state_next = WAIT_MEM;
         WAIT_MEM:
            if (data_in_valid) state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid            <= 1'b0;
         outbound_instruction <= NOP_WORD;
         outbound_address     <= '0;
         write                <= 1'b0;
         write_index          <= '0;
         write_data           <= '0;
         write_immediate      <= 1'b0;
         write_immediate_data <= 16'h0;
         write_immediate_type <= IT_UNSIGNED;
         alu_cycle            <= 1'b0;
         alu_result_latched   <= '0;
         alu_carry_in         <= 1'b0;
         jump                 <= 1'b0;
         flags                <= 4'h0;
         shadow               <= 8'd0;
      end else begin
         write           <= 1'b0;
         write_immediate <= 1'b0;
         alu_cycle       <= 1'b0;
         jump            <= 1'b0;
         // the pending load waits in the outbound slot with out_valid low
         if (state == WAIT_MEM) begin
            if (data_in_valid) begin
               write      <= 1'b1;
               write_data <= load_ext(outbound_instruction[26:25],
                                      outbound_instruction[24],
                                      data_in[31:0]);
               out_valid  <= 1'b1;
            end
         end else if (accept) begin
            out_valid            <= 1'b1;
            outbound_instruction <= inbound_instruction;
            outbound_address     <= inbound_address;
            if (squash) begin
               shadow               <= shadow - 8'd1;
               outbound_instruction <= NOP_WORD;
            end else if (opcode == OPCODE_LOAD) begin
               write_index <= index;
               if (data_in_valid) begin
                  write      <= 1'b1;
                  write_data <= load_ext(inbound_instruction[26:25],
                                         inbound_instruction[24],
                                         data_in[31:0]);
               end else begin
                  out_valid <= 1'b0;
               end
            end else if (opcode == OPCODE_LOADI) begin
               write_immediate      <= 1'b1;
               write_index          <= index;
               write_immediate_data <= inbound_instruction[15:0];
               write_immediate_type <= inbound_instruction[26:25];
            end else if (is_alu_op(opcode)) begin
               alu_cycle          <= 1'b1;
               write              <= 1'b1;
               write_index        <= index;
               write_data         <= alu_result;
               alu_result_latched <= alu_result;
               if (flag_en) begin
                  flags <= {alu_neg_out, alu_zero_out,
                            alu_carry_out, alu_over_out};
                  alu_carry_in <= alu_carry_out;
               end
            end else if ((opcode == OPCODE_BRANCH ||
                          opcode == OPCODE_JUMP) && taken) begin
               jump               <= 1'b1;
               alu_result_latched <= alu_result;
               shadow             <= 8'(BRANCH_SHADOW);
               if (inbound_instruction[24]) begin
                  write       <= 1'b1;
                  write_index <= index;
                  write_data  <= DATA_WIDTH'(inbound_address);
               end
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_execute_stage2_pipe.sv
// Directed + random bench for execute_stage2_pipe against a
// transaction-level reference model.
module tb_execute_stage2_pipe;
   import execute_stage2_pipe_pkg::*;

   localparam int SH = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] inbound_instruction = '0;
   logic [31:0] inbound_address = '0;
   logic [31:0] data_in = '0;
   logic        data_in_valid = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] outbound_instruction;
   logic [31:0] outbound_address;
   logic        write;
   logic [3:0]  write_index;
   logic [31:0] write_data;
   logic        write_immediate;
   logic [15:0] write_immediate_data;
   logic [1:0]  write_immediate_type;
   logic        alu_cycle;
   logic [31:0] alu_result = '0;
   logic [31:0] alu_result_latched;
   logic        alu_carry_out = 1'b0;
   logic        alu_zero_out = 1'b0;
   logic        alu_neg_out = 1'b0;
   logic        alu_over_out = 1'b0;
   logic        alu_carry_in;
   logic        jump;
   logic [3:0]  flags;

   execute_stage2_pipe #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32),
      .REG_INDEX_WIDTH(4), .BRANCH_SHADOW(SH)
   ) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .inbound_instruction(inbound_instruction),
      .inbound_address(inbound_address),
      .data_in(data_in), .data_in_valid(data_in_valid),
      .out_valid(out_valid), .out_ready(out_ready),
      .outbound_instruction(outbound_instruction),
      .outbound_address(outbound_address),
      .write(write), .write_index(write_index),
      .write_data(write_data),
      .write_immediate(write_immediate),
      .write_immediate_data(write_immediate_data),
      .write_immediate_type(write_immediate_type),
      .alu_cycle(alu_cycle), .alu_result(alu_result),
      .alu_result_latched(alu_result_latched),
      .alu_carry_out(alu_carry_out), .alu_zero_out(alu_zero_out),
      .alu_neg_out(alu_neg_out), .alu_over_out(alu_over_out),
      .alu_carry_in(alu_carry_in), .jump(jump), .flags(flags)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   bit          m_wait, m_ov;
   logic [31:0] m_instr, m_addr, m_pend, m_lat, m_wdata;
   logic [3:0]  m_flags, m_widx;
   logic        m_cin;
   logic [15:0] m_wid;
   logic [1:0]  m_wit;
   int          m_shadow;
   bit          e_write, e_wimm, e_alu, e_jump;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [4:0] op,
      input logic [1:0] w, input bit b24, input logic [3:0] idx,
      input logic [3:0] cond, input logic [11:0] low);
      return {op, w, b24, idx, 4'h0, cond, low};
   endfunction

   function automatic bit m_cond(input logic [3:0] c,
                                 input logic [3:0] f);
      bit n, z, cy, v;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c)
         COND_AL: return 1;
         COND_EQ: return z;
         COND_NE: return !z;
         COND_CS: return cy;
         COND_CC: return !cy;
         COND_MI: return n;
         COND_PL: return !n;
         COND_VS: return v;
         COND_VC: return !v;
         COND_HI: return !cy && !z;
         COND_LS: return cy || z;
         COND_GE: return n == v;
         COND_LT: return n != v;
         COND_GT: return !z && (n == v);
         COND_LE: return z || (n != v);
         default: return 0;
      endcase
   endfunction

   function automatic logic [31:0] m_ext(input logic [31:0] ins,
                                         input logic [31:0] d);
      longint val, span;
      int bits;
      bits = (ins[26:25] == 2'd0) ? 8 : (ins[26:25] == 2'd1) ? 16 : 32;
      span = 64'sd1 <<< bits;
      val = longint'(d) % span;
      if (ins[24] && val >= span / 2) val = val - span;
      return val[31:0];
   endfunction

   task automatic m_reset();
      m_wait = 0; m_ov = 0; m_instr = {OPCODE_NOP, 27'h0}; m_addr = 0;
      m_pend = 0; m_lat = 0; m_wdata = 0; m_flags = 0; m_widx = 0;
      m_cin = 0; m_wid = 0; m_wit = 0; m_shadow = 0;
   endtask

   task automatic check_reset();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_write", write, 0);
      chk("rst_wimm", write_immediate, 0);
      chk("rst_alu_cycle", alu_cycle, 0);
      chk("rst_jump", jump, 0);
      chk("rst_out_instr", outbound_instruction, {OPCODE_NOP, 27'h0});
      chk("rst_out_addr", outbound_address, 0);
      chk("rst_widx", write_index, 0);
      chk("rst_wdata", write_data, 0);
      chk("rst_wimm_data", write_immediate_data, 0);
      chk("rst_wimm_type", write_immediate_type, IT_UNSIGNED);
      chk("rst_alu_lat", alu_result_latched, 0);
      chk("rst_cin", alu_carry_in, 0);
      chk("rst_flags", flags, 0);
   endtask

   task automatic step(input bit iv, input logic [31:0] ins,
      input logic [31:0] addr, input bit dv, input logic [31:0] din,
      input bit ordy, input logic [31:0] ares = 32'h0,
      input logic [3:0] af = 4'h0);
      bit rdy, acc, upd;
      logic [4:0] op;
      @(negedge clock);
      in_valid = iv; inbound_instruction = ins; inbound_address = addr;
      data_in_valid = dv; data_in = din; out_ready = ordy;
      alu_result = ares;
      {alu_neg_out, alu_zero_out, alu_carry_out, alu_over_out} = af;
      rdy = !m_wait && (!m_ov || ordy);
      #1 chk("in_ready", in_ready, rdy);
      acc = iv && rdy;
      op = ins[31:27];
      e_write = 0; e_wimm = 0; e_alu = 0; e_jump = 0;
      if (m_wait) begin
         if (dv) begin
            e_write = 1; m_wdata = m_ext(m_pend, din);
            m_ov = 1; m_wait = 0; m_instr = m_pend;
         end
      end else if (acc) begin
         m_ov = 1; m_instr = ins; m_addr = addr;
         if (m_shadow > 0) begin
            m_shadow--; m_instr = {OPCODE_NOP, 27'h0};
         end else if (op == OPCODE_LOAD) begin
            m_widx = ins[23:20];
            if (dv) begin
               e_write = 1; m_wdata = m_ext(ins, din);
            end else begin
               m_wait = 1; m_ov = 0; m_pend = ins;
            end
         end else if (op == OPCODE_LOADI) begin
            e_wimm = 1; m_widx = ins[23:20];
            m_wid = ins[15:0]; m_wit = ins[26:25];
         end else if (op == OPCODE_ALU || op == OPCODE_ALUM ||
                      op == OPCODE_ALUMI) begin
            e_alu = 1; e_write = 1; m_widx = ins[23:20];
            m_wdata = ares; m_lat = ares;
`ifdef FLAG_SET_SELECT_EN
            upd = ins[24];
`else
            upd = 1;
`endif
            if (upd) begin
               m_flags = af; m_cin = af[1];
            end
         end else if ((op == OPCODE_BRANCH || op == OPCODE_JUMP) &&
                      m_cond(ins[15:12], m_flags)) begin
            e_jump = 1; m_lat = ares; m_shadow = SH;
            if (ins[24]) begin
               e_write = 1; m_widx = ins[23:20]; m_wdata = addr;
            end
         end
      end else if (ordy) begin
         m_ov = 0;
      end
      @(posedge clock);
      #1;
      chk("out_valid", out_valid, m_ov);
      chk("write", write, e_write);
      chk("write_immediate", write_immediate, e_wimm);
      chk("alu_cycle", alu_cycle, e_alu);
      chk("jump", jump, e_jump);
      chk("flags", flags, m_flags);
      chk("alu_carry_in", alu_carry_in, m_cin);
      chk("alu_result_latched", alu_result_latched, m_lat);
      if (m_ov) begin
         chk("out_instr", outbound_instruction, m_instr);
         chk("out_addr", outbound_address, m_addr);
      end
      if (e_write) begin
         chk("write_index", write_index, m_widx);
         chk("write_data", write_data, m_wdata);
      end
      if (e_wimm) begin
         chk("wimm_index", write_index, m_widx);
         chk("wimm_data", write_immediate_data, m_wid);
         chk("wimm_type", write_immediate_type, m_wit);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] ins;
      logic [4:0]  op;
      int          k;
      m_reset();
      #12 check_reset();
      @(negedge clock);
      reset = 1'b0;

      // ALU sets Z, branch EQ taken, shadow squashes two, NE not taken
      step(1, mk(OPCODE_ALU, 0, 1, 4'h3, 0, 0), 32'h10, 0, 0, 1,
           32'h0, 4'b0100);
      step(1, mk(OPCODE_BRANCH, 0, 0, 0, COND_EQ, 0), 32'h14, 0, 0, 1,
           32'h1234_5678);
      chk("eq_jump", jump, 1);
      chk("eq_latched", alu_result_latched, 32'h1234_5678);
      step(1, mk(OPCODE_ALU, 0, 1, 4'h5, 0, 0), 32'h18, 0, 0, 1,
           32'h55, 4'b0010);
      step(1, mk(OPCODE_ALU, 0, 1, 4'h6, 0, 0), 32'h1C, 0, 0, 1,
           32'h66, 4'b0010);
      step(1, mk(OPCODE_BRANCH, 0, 0, 0, COND_NE, 0), 32'h20, 0, 0, 1,
           32'hDEAD_BEEF);
      chk("ne_no_jump", jump, 0);

      // late byte load with sign extension
      step(1, mk(OPCODE_LOAD, CW_BYTE, 1, 4'h7, 0, 0), 32'h24, 0, 0, 1);
      step(1, mk(OPCODE_NOP, 0, 0, 0, 0, 0), 32'h28, 0, 0, 1);
      step(1, mk(OPCODE_NOP, 0, 0, 0, 0, 0), 32'h28, 0, 0, 1);
      step(1, mk(OPCODE_NOP, 0, 0, 0, 0, 0), 32'h28, 1, 32'hF0, 1);
      chk("load_byte_sext", write_data, 32'hFFFF_FFF0);
      step(0, 0, 0, 0, 0, 1);

      // jump-and-link, then two squashed ALU ops, third writes
      step(1, mk(OPCODE_JUMP, 0, 1, 4'hE, COND_AL, 0), 32'h100, 0, 0, 1,
           32'h200);
      chk("jal_index", write_index, 4'hE);
      chk("jal_data", write_data, 32'h100);
      for (int i = 0; i < 3; i++)
         step(1, mk(OPCODE_ALUM, 0, 1, 4'h1, 0, 0), 32'h104 + 4 * i,
              0, 0, 1, 32'h900 + i, 4'b0001);
      chk("post_shadow_write", write_data, 32'h902);

      // back-pressure
      step(1, mk(OPCODE_ALUMI, 0, 1, 4'h2, 0, 0), 32'h40, 0, 0, 1,
           32'hABCD, 4'b1000);
      for (int i = 0; i < 4; i++)
         step(1, mk(OPCODE_LOADI, 2'd1, 0, 4'h9, 0, 12'h123), 32'h44,
              0, 0, 0);
      step(1, mk(OPCODE_LOADI, 2'd1, 0, 4'h9, 0, 12'h123), 32'h44,
           0, 0, 1);

      // flag-set select: carry out ignored unless bit 24 set
      step(1, mk(OPCODE_ALU, 0, 0, 4'h4, 0, 0), 32'h50, 0, 0, 1,
           32'h1, 4'b0010);
      step(1, mk(OPCODE_ALU, 0, 1, 4'h4, 0, 0), 32'h54, 0, 0, 1,
           32'h2, 4'b0010);
      chk("carry_set", flags[1], 1);

      // reset while waiting on memory
      step(1, mk(OPCODE_LOAD, CW_WORD, 0, 4'h8, 0, 0), 32'h60, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      #2 reset = 1'b1;
      m_reset();
      #1 check_reset();
      @(negedge clock);
      reset = 1'b0;
      step(0, 0, 0, 1, 32'h1234, 1);
      step(0, 0, 0, 1, 32'h1234, 1);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         k = $urandom_range(0, 8);
         case (k)
            0: op = OPCODE_NOP;
            1: op = OPCODE_ALU;
            2: op = OPCODE_ALUM;
            3: op = OPCODE_ALUMI;
            4: op = OPCODE_LOAD;
            5: op = OPCODE_LOADI;
            6: op = OPCODE_BRANCH;
            7: op = OPCODE_JUMP;
            default: op = 5'h15;
         endcase
         ins = $urandom;
         ins[31:27] = op;
         step($urandom_range(0, 3) != 0, ins, $urandom,
              $urandom_range(0, 2) == 0, $urandom,
              $urandom_range(0, 3) != 0, $urandom,
              4'($urandom_range(0, 15)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
